pool2d_stream: RTL and testbench
================================

# pool2d_stream

Parametrised 2x2/stride-2 pooling engine on the activation output stream. Consumes one raster-order feature-map channel (one pixel per valid cycle), buffers one row of column-pair partials, and emits one pooled value per 2x2 window in either max or average mode. Successor to the fixed 2x2 pooling stage: it adds runtime-configurable row width, mode select, stall tolerance and frame-error detection. Sits between the activation unit and the output writeback.

## Interface
Parameters:
- DATA_WIDTH, 8, unsigned pixel width
- MAX_WIDTH, 32, largest supported feature-map row width; even, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cfg_width_i  in  $clog2(MAX_WIDTH+1)  row width in pixels; sampled at first pixel of frame
- cfg_mode_i  in  1  0 = max, 1 = average; sampled with cfg_width_i
- act_valid_i  in  1  input pixel valid
- act_last_i  in  1  final pixel of frame; qualified by act_valid_i
- act_result_i  in  DATA_WIDTH  input pixel
- pool_valid_o  out  1  pooled result valid, one-cycle pulse
- pool_last_o  out  1  final pooled result of frame; only with pool_valid_o
- pool_result_o  out  DATA_WIDTH  pooled value
- frame_err_o  out  1  one-cycle pulse: act_last_i arrived off a window boundary

## Operation
- No backpressure. act_valid_i may drop for any number of cycles mid-frame. Logic advances only on accepted pixels.
- Config latch: in S_IDLE, the first accepted pixel latches width and mode.
  - Width LSB is ignored.
  - Width values below 2 are treated as 2; values above MAX_WIDTH are treated as MAX_WIDTH.
- Counters:
  - col counts 0..W-1 and wraps to 0 at end of row.
  - row parity toggles on each column wrap.
- State machine:
  - S_IDLE goes to S_EVEN on the first pixel. That pixel is processed as row 0, col 0.
  - S_EVEN goes to S_ODD on the column wrap.
  - S_ODD goes to S_EVEN on the column wrap.
  - Any state goes to S_IDLE on accepted act_last_i.
- Pair register: holds the even-column pixel. On the following odd-column pixel, pair value p = max(a,b) in max mode, or a+b (DATA_WIDTH+1 bits) in average mode.
- Even row: p is written to line buffer entry col>>1.
- Odd row: p is combined with line buffer entry col>>1.
  - Max mode: max(p, entry).
  - Average mode: (p + entry + 2) >> 2, computed at DATA_WIDTH+2 bits. Round-half-up; the result never overflows DATA_WIDTH.
  - The result is registered to the outputs.
- act_last_i at odd row, odd col: final window is emitted with pool_last_o=1, then S_IDLE.
- act_last_i at any other position:
  - Partial window is discarded; no pool_valid_o.
  - frame_err_o pulses; return to S_IDLE.
  - Line buffer contents become don't-care.
- Row count is not checked. The frame ends only on act_last_i.

## Timing
- Reset values: all outputs 0; state S_IDLE; counters 0.
  - Line buffer needs no reset; it is always written before read within a frame.
- Result latency: pool_valid_o and pool_result_o rise exactly 1 cycle after the accepting edge of the odd-row, odd-col pixel.
- pool_last_o is coincident with its pool_valid_o.
- frame_err_o asserts 1 cycle after the offending act_last_i.
- Back-to-back frames: a pixel accepted the cycle after act_last_i starts the new frame, latching fresh config. Zero dead cycles.
- Throughput:
  - Every cycle: full rate in, with no internal stall.
  - Worst case out: one result per 2 cycles.
- Line buffer access: read and write of the same entry never happen in the same row, so there is no collision. Use a registered write with combinational read.
- rst mid-frame: next-cycle outputs 0, state S_IDLE. No output from the aborted frame ever appears.

## Structure
- pool_pkg holds:
  - state enum (S_IDLE, S_EVEN, S_ODD)
  - mode constants POOL_MAX=1'b0, POOL_AVG=1'b1
  - a function for the sum-width localparam
- Sub-module pool_line_buffer: MAX_WIDTH/2 entries x (DATA_WIDTH+1) bits, with write enable/address/data and read address/data.
- Top: FSM, counters, pair register, combine logic, output registers.

## Test plan
- 4x4, max, pixels 0..15 raster, continuous valid, last on 15 -> outputs 5, 7, 13, 15; pool_last_o only with 15; frame_err_o never high.
- 4x4, average, same input -> outputs 3, 5, 11, 13; check (sum+2)>>2 rounding.
- 4x4, max, valid low every other cycle plus a random 5-cycle gap -> identical outputs, each 1 cycle after its completing pixel.
- act_last_i on pixel index 6 of a 4x4 frame -> no pool_valid_o for the partial window (after 5 has been emitted), one frame_err_o pulse. Then an immediately following 2x2 frame of 9, 3, 4, 8 in max mode -> single output 9 with pool_last_o.
- rst asserted on pixel 10 of a 4x4 frame -> all outputs 0 next cycle. A following frame at MAX_WIDTH x 2, average, all pixels 255 -> MAX_WIDTH/2 outputs of 255, last flagged.
- cfg_width_i=7 (treated as 6) and cfg_width_i changed mid-frame -> mid-frame change is ignored; 6x2 max frame yields 3 correct outputs.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2/stride-2 pooling engine.
// Holds the frame-position state encoding, the pooling-mode constants and
// width helpers used by pool2d_stream and pool_line_buffer.
package pool_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVEN = 2'd1,
    S_ODD  = 2'd2
  } pool_state_t;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // A 2x2 average adds two (DATA_WIDTH+1)-bit pair sums plus a rounding
  // constant, so it needs two bits of headroom over the pixel width.
  function automatic int pool_sum_width(input int data_width);
    return data_width + 2;
  endfunction

  // Address width for a buffer of max_width/2 column-pair entries.
  function automatic int pool_addr_width(input int max_width);
    return (max_width > 2) ? $clog2(max_width / 2) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row store of column-pair partials (max or pair sum) for the pooler.
// Latency: write lands at the clock edge; read is combinational.
// Backpressure: none; the owner guarantees read and write never target the same row.
// Ports: clk; we/waddr/wdata write port; raddr/rdata asynchronous read port.
// Contents are not reset: every entry is written in an even row before any
// odd-row read of it within the same frame.
module pool_line_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool2d_stream.sv
// 2x2/stride-2 max/average pooling of one raster-order channel stream.
// Latency: result registered 1 cycle after the odd-row/odd-col pixel is accepted.
// Backpressure: none; input may idle at any point, logic advances on accepted pixels only.
// Ports: clk/rst (sync, active-high); cfg_width_i/cfg_mode_i latched on the
// first pixel of a frame; act_* pixel input stream with frame-last marker;
// pool_* pooled output stream; frame_err_o flags a last pixel off a window boundary.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(MAX_WIDTH+1)-1:0] cfg_width_i,
  input  logic                           cfg_mode_i,
  input  logic                           act_valid_i,
  input  logic                           act_last_i,
  input  logic [DATA_WIDTH-1:0]          act_result_i,
  output logic                           pool_valid_o,
  output logic                           pool_last_o,
  output logic [DATA_WIDTH-1:0]          pool_result_o,
  output logic                           frame_err_o
);

  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int CW = $clog2(MAX_WIDTH);
  localparam int PW = DATA_WIDTH + 1;
  localparam int SW = pool_sum_width(DATA_WIDTH);
  localparam int AW = pool_addr_width(MAX_WIDTH);

  localparam logic [WW-1:0] W_MIN = WW'(2);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_WIDTH);

  pool_state_t           state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         last_col_q, last_col_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] pair_q;

  logic [WW-1:0]         w_even, w_eff;
  logic [CW-1:0]         cur_last_col;
  logic                  cur_mode, odd_row, odd_col, col_wrap, win_done;
  logic [PW-1:0]         pair_val, lb_rd_data;
  logic [SW-1:0]         avg_sum;
  logic [DATA_WIDTH-1:0] win_result;
  logic                  lb_we;
  logic [AW-1:0]         lb_addr;
  logic                  valid_d, last_d, err_d;
  logic [DATA_WIDTH-1:0] result_d;

  // Effective row width: force even, then clamp into [2, MAX_WIDTH].
  always_comb begin
    w_even = cfg_width_i & ~WW'(1);
    if (w_even < W_MIN) begin
      w_eff = W_MIN;
    end else if (w_even > W_MAX) begin
      w_eff = W_MAX;
    end else begin
      w_eff = w_even;
    end
  end

  // In S_IDLE the live config is used for the first pixel; col_q is 0 there.
  assign cur_last_col = (state_q == S_IDLE) ? CW'(w_eff - WW'(1)) : last_col_q;
  assign cur_mode     = (state_q == S_IDLE) ? cfg_mode_i : mode_q;
  assign odd_row      = (state_q == S_ODD);
  assign odd_col      = col_q[0];
  assign col_wrap     = (col_q == cur_last_col);
  assign win_done     = odd_row & odd_col;

  // Column-pair partial: even-column pixel held in pair_q, current pixel is odd column.
  always_comb begin
    if (cur_mode == POOL_AVG) begin
      pair_val = {1'b0, pair_q} + {1'b0, act_result_i};
    end else begin
      pair_val = (act_result_i > pair_q) ? {1'b0, act_result_i} : {1'b0, pair_q};
    end
  end

  // Odd-row combine with the partial stored from the row above.
  // Round-half-up average: the +2 before >>2 cannot overflow SW bits.
  always_comb begin
    avg_sum = SW'(pair_val) + SW'(lb_rd_data) + SW'(2);
    if (mode_q == POOL_AVG) begin
      win_result = DATA_WIDTH'(avg_sum >> 2);
    end else begin
      win_result = DATA_WIDTH'((pair_val > lb_rd_data) ? pair_val : lb_rd_data);
    end
  end

  // Even rows write, odd rows read, so one shared address never collides.
  assign lb_we   = act_valid_i & odd_col & ~odd_row;
  assign lb_addr = AW'(col_q >> 1);

  pool_line_buffer #(
    .DEPTH (MAX_WIDTH / 2),
    .AW    (AW),
    .DW    (PW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_val),
    .raddr (lb_addr),
    .rdata (lb_rd_data)
  );

  // Next-state, counters and next outputs.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    last_col_d = last_col_q;
    mode_d     = mode_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    err_d      = 1'b0;
    result_d   = '0;
    if (act_valid_i) begin
      if (state_q == S_IDLE) begin
        last_col_d = cur_last_col;
        mode_d     = cur_mode;
      end
      valid_d  = win_done;
      result_d = win_done ? win_result : '0;
      if (act_last_i) begin
        // A last pixel off the window grid drops the partial window.
        last_d  = win_done;
        err_d   = ~win_done;
        state_d = S_IDLE;
        col_d   = '0;
      end else if (col_wrap) begin
        col_d   = '0;
        state_d = odd_row ? S_EVEN : S_ODD;
      end else begin
        col_d = col_q + CW'(1);
        if (state_q == S_IDLE) begin
          state_d = S_EVEN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      last_col_q    <= '0;
      mode_q        <= POOL_MAX;
      pool_valid_o  <= 1'b0;
      pool_last_o   <= 1'b0;
      pool_result_o <= '0;
      frame_err_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      last_col_q    <= last_col_d;
      mode_q        <= mode_d;
      pool_valid_o  <= valid_d;
      pool_last_o   <= last_d;
      pool_result_o <= result_d;
      frame_err_o   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (act_valid_i && !odd_col) begin
      pair_q <= act_result_i;
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Randomised self-checking bench for pool2d_stream.
// Expected results come from a frame-level model: each window is computed
// from the 2x2 pixel neighbourhood in the stored frame.
module tb_pool2d_stream;

  localparam int DW  = 8;
  localparam int MAX = 32;
  localparam int WW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] cfg_width_i;
  logic          cfg_mode_i;
  logic          act_valid_i;
  logic          act_last_i;
  logic [DW-1:0] act_result_i;
  logic          pool_valid_o;
  logic          pool_last_o;
  logic [DW-1:0] pool_result_o;
  logic          frame_err_o;

  pool2d_stream #(.DATA_WIDTH(DW), .MAX_WIDTH(MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_width_i   (cfg_width_i),
    .cfg_mode_i    (cfg_mode_i),
    .act_valid_i   (act_valid_i),
    .act_last_i    (act_last_i),
    .act_result_i  (act_result_i),
    .pool_valid_o  (pool_valid_o),
    .pool_last_o   (pool_last_o),
    .pool_result_o (pool_result_o),
    .frame_err_o   (frame_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
    bit last;
  } exp_t;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   err_q[$];
  int   px[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  function automatic int eff_w(input int w);
    int v;
    v = w & ~1;
    if (v < 2) v = 2;
    if (v > MAX) v = MAX;
    return v;
  endfunction

  // Outputs are sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (pool_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("valid_without_expectation", 32'(pool_valid_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("result", 32'(pool_result_o), 32'(mon_e.val));
        chk("last_flag", 32'(pool_last_o), 32'(mon_e.last));
      end
    end else begin
      if (pool_last_o) chk("last_without_valid", 32'(pool_last_o), 32'd0);
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_valid", 32'(pool_valid_o), 32'd1);
        void'(exp_q.pop_front());
      end
    end
    if (frame_err_o) begin
      if (err_q.size() == 0) begin
        chk("err_without_expectation", 32'(frame_err_o), 32'd0);
      end else begin
        chk("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
      end
    end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
      chk("missing_err", 32'(frame_err_o), 32'd1);
      void'(err_q.pop_front());
    end
  end

  task automatic idle_cycle();
    @(negedge clk);
    act_valid_i  = 1'b0;
    act_last_i   = 1'($urandom);
    act_result_i = DW'($urandom);
    cfg_width_i  = WW'($urandom);
    cfg_mode_i   = 1'($urandom);
  endtask

  // Drive n pixels of px[] as one frame (last on pixel n-1).
  // gap: 0 continuous, 1 every other cycle idle plus one 5-cycle gap, 2 random gaps.
  // abort_at >= 0 asserts rst together with that pixel.
  task automatic run_frame(input int wcfg, input bit mode, input int n,
                           input int gap, input int abort_at);
    int w, g5, idle, r, c, a, b, d, e, val;
    w  = eff_w(wcfg);
    g5 = $urandom_range(n - 1, 0);
    for (int k = 0; k < n; k++) begin
      idle = 0;
      if (gap == 1) idle = ((k > 0) ? 1 : 0) + ((k == g5) ? 5 : 0);
      if (gap == 2) idle = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0;
      repeat (idle) idle_cycle();
      @(negedge clk);
      act_valid_i  = 1'b1;
      act_result_i = DW'(px[k]);
      act_last_i   = (k == n - 1);
      if (k == 0) begin
        cfg_width_i = WW'(wcfg);
        cfg_mode_i  = mode;
      end else begin
        cfg_width_i = WW'($urandom);
        cfg_mode_i  = 1'($urandom);
      end
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        act_valid_i = 1'b0;
        chk("abort_valid", 32'(pool_valid_o), 32'd0);
        chk("abort_last", 32'(pool_last_o), 32'd0);
        chk("abort_result", 32'(pool_result_o), 32'd0);
        chk("abort_err", 32'(frame_err_o), 32'd0);
        return;
      end
      r = k / w;
      c = k % w;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        a = px[(r - 1) * w + c - 1];
        b = px[(r - 1) * w + c];
        d = px[k - 1];
        e = px[k];
        if (mode) begin
          val = (a + b + d + e + 2) / 4;
        end else begin
          val = a;
          if (b > val) val = b;
          if (d > val) val = d;
          if (e > val) val = e;
        end
        exp_q.push_back('{cyc: cyc + 1, val: val, last: (k == n - 1)});
      end else if (k == n - 1) begin
        err_q.push_back(cyc + 1);
      end
    end
  endtask

  task automatic fill_ramp(input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(i);
  endtask

  task automatic fill_rand(input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(int'($urandom_range(255, 0)));
  endtask

  initial begin
    int wl[8] = '{0, 1, 2, 7, 12, 32, 40, 63};
    int w, rows, n;
    rst          = 1'b1;
    act_valid_i  = 1'b0;
    act_last_i   = 1'b0;
    act_result_i = '0;
    cfg_width_i  = WW'(4);
    cfg_mode_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(pool_valid_o), 32'd0);
    chk("reset_last", 32'(pool_last_o), 32'd0);
    chk("reset_result", 32'(pool_result_o), 32'd0);
    chk("reset_err", 32'(frame_err_o), 32'd0);
    rst = 1'b0;

    // 4x4 ramp: max then average, continuous.
    fill_ramp(16);
    run_frame(4, 1'b0, 16, 0, -1);
    run_frame(4, 1'b1, 16, 0, -1);
    // Same ramp with stalls.
    run_frame(4, 1'b0, 16, 1, -1);
    // Last on pixel 6, then an immediate 2x2 frame.
    run_frame(4, 1'b0, 7, 0, -1);
    px.delete();
    px.push_back(9); px.push_back(3); px.push_back(4); px.push_back(8);
    run_frame(2, 1'b0, 4, 0, -1);
    // Reset mid-frame on pixel 10, and on a window-completing pixel.
    fill_ramp(16);
    run_frame(4, 1'b0, 16, 0, 10);
    run_frame(4, 1'b1, 16, 0, 15);
    // Full-width average of saturated pixels.
    px.delete();
    for (int i = 0; i < 2 * MAX; i++) px.push_back(255);
    run_frame(MAX, 1'b1, 2 * MAX, 0, -1);
    // Odd width rounds down, mid-frame config changes ignored.
    fill_rand(12);
    run_frame(7, 1'b0, 12, 0, -1);

    // Random frames over widths, modes, row counts, stalls and bad last.
    for (int f = 0; f < 16; f++) begin
      w    = wl[$urandom_range(7, 0)];
      rows = $urandom_range(4, 1);
      n    = eff_w(w) * rows;
      if ($urandom_range(3, 0) == 0) n = $urandom_range(n, 1);
      fill_rand(n);
      run_frame(w, 1'($urandom), n, $urandom_range(2, 0), -1);
    end

    repeat (6) idle_cycle();
    chk("leftover_results", 32'(exp_q.size()), 32'd0);
    chk("leftover_errs", 32'(err_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
